// File: rtl/ethpipe_tx_pkg.sv
// Shared TX slot definitions: slot header layout, pointer width, scheduler
// state encoding and the frame footprint helper used by scheduler and sender.
package ethpipe_tx_pkg;

  localparam int unsigned SLOT_HDR_WORDS = 7;
  localparam int unsigned SLOT_TS_OFS    = 1;
  localparam int unsigned SLOT_HASH_OFS  = 5;
  localparam int unsigned SLOT_PTR_W     = 14;
  localparam int unsigned SLOT_WORD_W    = 16;
  localparam int unsigned TS_W           = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_WAIT,
    S_RELEASE,
    S_HALT
  } sched_state_t;

  // Words occupied by a frame in the slot: header plus payload rounded down
  // to whole words (odd trailing byte shares the last header-aligned word).
  function automatic logic [SLOT_PTR_W-1:0] slot_footprint(input logic [SLOT_WORD_W-1:0] len);
    return SLOT_PTR_W'(SLOT_HDR_WORDS) + SLOT_PTR_W'(len[SLOT_PTR_W-1:1]);
  endfunction

endpackage

// File: rtl/tx_release_sched_fetch.sv
// slot_hdr_fetch: reads frame length and 64-bit timestamp (words 0..4 from
// the frame head) through the scheduler RAM port and holds them.
// Ports:
//   gmii_tx_clk, sys_rst : clock, synchronous active-high reset
//   start                : one-cycle pulse, begin fetching at base
//   base                 : frame head address
//   rd_q                 : RAM data, one cycle after rd_addr
//   rd_addr              : RAM read address
//   last_c               : high in the cycle the final header word is captured
//   hdr_valid            : len_r/ts_r hold a complete header
//   len_r, ts_r          : captured frame length and launch timestamp
module slot_hdr_fetch
  import ethpipe_tx_pkg::*;
(
  input  logic                   gmii_tx_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  input  logic [SLOT_PTR_W-1:0]  base,
  input  logic [SLOT_WORD_W-1:0] rd_q,
  output logic [SLOT_PTR_W-1:0]  rd_addr,
  output logic                   last_c,
  output logic                   hdr_valid,
  output logic [SLOT_WORD_W-1:0] len_r,
  output logic [TS_W-1:0]        ts_r
);

  // phase p (1..6): address base+p-1 is on the port while p <= 5 and the
  // word for address base+p-2 is on rd_q.
  localparam int unsigned      PH_W         = 3;
  localparam logic [PH_W-1:0]  PH_LEN       = PH_W'(2);
  localparam logic [PH_W-1:0]  PH_TS0       = PH_W'(SLOT_TS_OFS + 2);
  localparam logic [PH_W-1:0]  PH_ADDR_LAST = PH_W'(SLOT_HASH_OFS - 1);
  localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(SLOT_HASH_OFS + 1);

  logic [PH_W-1:0] phase;

  assign last_c = (phase == PH_LAST);

  // Address sequencer and capture registers
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      phase     <= '0;
      rd_addr   <= '0;
      hdr_valid <= 1'b0;
      len_r     <= '0;
      ts_r      <= '0;
    end else if (start) begin
      phase     <= PH_W'(1);
      rd_addr   <= base;
      hdr_valid <= 1'b0;
    end else if (phase != '0) begin
      if (phase <= PH_ADDR_LAST) rd_addr <= rd_addr + SLOT_PTR_W'(1);
      if (phase == PH_LEN) len_r <= rd_q;
      // Timestamp arrives MSW first, so shift each word in from the bottom
      if (phase >= PH_TS0) ts_r <= {ts_r[TS_W-SLOT_WORD_W-1:0], rd_q};
      if (last_c) hdr_valid <= 1'b1;
      phase <= last_c ? '0 : phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/tx_release_sched.sv
// tx_release_sched: walks complete frames in the TX slot, holds each until
// global_counter + TX_LEAD reaches its timestamp, then publishes it to the
// GMII sender by advancing mem_wr_ptr.
// Ports:
//   gmii_tx_clk, sys_rst      : clock, synchronous active-high reset
//   global_counter            : free-running time base
//   sched_en                  : release enable
//   host_wr_ptr               : end of complete frames written by the host
//   sched_rd_addr, sched_rd_q : scheduler read port of the slot RAM
//   mem_wr_ptr, mem_rd_ptr    : released boundary / sender read pointer
//   tx_busy                   : sender has unsent released data
//   release_cnt, late_cnt     : released / released-late frame counters
//   sched_err                 : sticky malformed-frame flag
module tx_release_sched
  import ethpipe_tx_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = 1522,
  parameter int unsigned TX_LEAD       = 16
) (
  input  logic                   gmii_tx_clk,
  input  logic                   sys_rst,
  input  logic [TS_W-1:0]        global_counter,
  input  logic                   sched_en,
  input  logic [SLOT_PTR_W-1:0]  host_wr_ptr,
  output logic [SLOT_PTR_W-1:0]  sched_rd_addr,
  input  logic [SLOT_WORD_W-1:0] sched_rd_q,
  output logic [SLOT_PTR_W-1:0]  mem_wr_ptr,
  input  logic [SLOT_PTR_W-1:0]  mem_rd_ptr,
  output logic                   tx_busy,
  output logic [31:0]            release_cnt,
  output logic [31:0]            late_cnt,
  output logic                   sched_err
);

  localparam logic [SLOT_WORD_W-1:0] MAX_LEN = SLOT_WORD_W'(MAX_FRAME_LEN);
  localparam logic [TS_W-1:0]        LEAD    = TS_W'(TX_LEAD);

  sched_state_t state, state_nxt;

  logic [SLOT_PTR_W-1:0]  head;
  logic [SLOT_PTR_W-1:0]  foot_c;
  logic [SLOT_PTR_W-1:0]  avail_c;
  logic [SLOT_WORD_W-1:0] len_r;
  logic [TS_W-1:0]        ts_r;
  logic                   hdr_valid;
  logic                   last_c;
  logic                   len_bad_c;
  logic                   due_c;
  logic                   start_c;
  logic                   release_c;
  logic                   late_c;
  logic                   err_c;

  slot_hdr_fetch u_fetch (
    .gmii_tx_clk (gmii_tx_clk),
    .sys_rst     (sys_rst),
    .start       (start_c),
    .base        (head),
    .rd_q        (sched_rd_q),
    .rd_addr     (sched_rd_addr),
    .last_c      (last_c),
    .hdr_valid   (hdr_valid),
    .len_r       (len_r),
    .ts_r        (ts_r)
  );

  assign foot_c    = slot_footprint(len_r);
  assign avail_c   = host_wr_ptr - head;
  assign len_bad_c = (len_r == '0) || (len_r > MAX_LEN);
  // 64-bit wrapping sum; ts 0 means "send as soon as possible"
  assign due_c     = sched_en && ((ts_r == '0) || (global_counter + LEAD >= ts_r));
  assign tx_busy   = (mem_rd_ptr != mem_wr_ptr);

  // State register
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and datapath strobes
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    release_c = 1'b0;
    late_c    = 1'b0;
    err_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (head != host_wr_ptr) begin
          start_c   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (last_c) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Host may still be streaming the frame body; wait for all of it
        if (hdr_valid) begin
          if (len_bad_c) begin
            err_c     = 1'b1;
            state_nxt = S_HALT;
          end else if (avail_c >= foot_c) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (due_c) begin
          late_c    = (ts_r != '0) && (global_counter > ts_r);
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        release_c = 1'b1;
        state_nxt = S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame walk pointer, released boundary, counters and error flag
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      head        <= '0;
      mem_wr_ptr  <= '0;
      release_cnt <= '0;
      late_cnt    <= '0;
      sched_err   <= 1'b0;
    end else begin
      if (release_c) begin
        head        <= head + foot_c;
        mem_wr_ptr  <= head + foot_c;
        release_cnt <= release_cnt + 32'd1;
      end
      if (late_c) late_cnt <= late_cnt + 32'd1;
      if (err_c)  sched_err <= 1'b1;
    end
  end

endmodule

// File: doc/tx_release_sched.md
# tx_release_sched

Timestamp-driven release scheduler for the TX frame slot, in the `gmii_tx_clk` domain, between the host-side slot writer and the GMII sender. The writer advances `host_wr_ptr` as complete frames land in the slot RAM. This block walks those frames in order through a second read port, holds each one until `global_counter` reaches its launch timestamp, then publishes it to the sender by advancing `mem_wr_ptr`. The sender transmits everything between its `mem_rd_ptr` and `mem_wr_ptr`.

## Interface
Parameters:
- `MAX_FRAME_LEN`, default 1522: largest legal `frame_len` in bytes.
- `TX_LEAD`, default 16: a frame is released once `global_counter + TX_LEAD >= timestamp`. This compensates for sender preamble and pipeline delay.

Ports:
- `gmii_tx_clk` in 1: sole clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `global_counter` in 64: free-running time base.
- `sched_en` in 1: release enable. While 0, no release occurs and the pending frame stays pending.
- `host_wr_ptr` in 14: word pointer one past the last complete frame written by the host.
- `sched_rd_addr` out 14: slot RAM read address on the scheduler port.
- `sched_rd_q` in 16: slot RAM read data, valid one cycle after its address.
- `mem_wr_ptr` out 14: released-frame boundary, to the sender.
- `mem_rd_ptr` in 14: sender read pointer, used for status only.
- `tx_busy` out 1: `mem_rd_ptr != mem_wr_ptr`.
- `release_cnt` out 32: count of frames released.
- `late_cnt` out 32: count of frames released after their timestamp.
- `sched_err` out 1: sticky flag for a malformed frame.

## Operation
Slot frame format, in 16-bit words from frame head `h`, all addresses mod 2^14:
- `h`: `frame_len`.
- `h+1..h+4`: timestamp, bits 63:48 first.
- `h+5..h+6`: hash.
- Then payload.
- Footprint `F = 7 + frame_len[13:1]` words. The next frame head is `h + F`.

Internal state: `head` is the next frame to schedule. Reset values: `head`, `mem_wr_ptr` and `sched_rd_addr` = 0; counters = 0; `sched_err` = 0.

State machine:
- `S_IDLE`: when `head != host_wr_ptr`, go to `S_FETCH`.
- `S_FETCH`: drive `sched_rd_addr = head+0 .. head+4` on five consecutive cycles. Capture `sched_rd_q` one cycle after each address into `len_r` and `ts_r[63:0]`. This takes 6 cycles, then go to `S_CHECK`.
- `S_CHECK`, evaluated every cycle:
  - If `len_r == 0` or `len_r > MAX_FRAME_LEN`: set `sched_err` and go to `S_HALT`.
  - Else if `(host_wr_ptr - head) mod 2^14 >= F`: go to `S_WAIT`.
  - Otherwise stay. The host pointer may still be moving.
- `S_WAIT`:
  - Release condition: `sched_en && (ts_r == 0 || global_counter + TX_LEAD >= ts_r)`. The sum is 64-bit and wraps.
  - On release, go to `S_RELEASE`.
  - At release, if `ts_r != 0 && global_counter > ts_r`, increment `late_cnt`.
- `S_RELEASE`: for one cycle, set `mem_wr_ptr <= head + F`, `head <= head + F`, and increment `release_cnt`. Then go to `S_IDLE`.
- `S_HALT`: outputs frozen; leave only via `sys_rst`.

Rules:
- `mem_wr_ptr` changes only in `S_RELEASE` and always lands on a frame boundary. It never passes `host_wr_ptr`.
- All pointer arithmetic is 14-bit modulo. Wrap at 16383→0 needs no special casing.
- Counters wrap at 2^32 with no saturation.
- `mem_rd_ptr` does not throttle release. Slot-space protection belongs to the host writer.
- Reset mid-frame: all state returns to reset values the following cycle. The sender is reset by the same `sys_rst`.

## Timing
- Minimum latency, from `head != host_wr_ptr` to the `mem_wr_ptr` update, with an already-due timestamp and complete data: IDLE 1 + FETCH 6 + CHECK 1 + WAIT 1 + RELEASE 1 = 10 cycles.
- Back-to-back frames need at least 10 cycles each. This is far below the 72+ cycle sender frame time.
- A `sched_en` drop in `S_WAIT` holds the frame. The release follows on the first cycle where `sched_en=1` and the time condition holds.
- `tx_busy` is combinational from the pointers.

## Structure
- Shared package `ethpipe_tx_pkg`:
  - Constants `SLOT_HDR_WORDS=7`, `SLOT_TS_OFS=1`, `SLOT_HASH_OFS=5`, `SLOT_PTR_W=14`.
  - The state enum.
  - The footprint function `F(len)`.
- The sender uses the same constants.
- One natural sub-module: `slot_hdr_fetch`, the 5-word read sequencer with capture registers, emitting `hdr_valid`, `len_r`, `ts_r`.

## Test plan
- Timestamp 0, `frame_len=60`, host pointer advanced by 37 → `mem_wr_ptr=37` after 10 cycles; `release_cnt=1`; `late_cnt=0`.
- `ts=1000`, `TX_LEAD=16`, counter starting at 900 → release on the cycle the counter reads 984; `late_cnt=0`.
- `ts=500` with counter already at 800 → immediate release; `late_cnt=1`.
- Head at 16380, `frame_len=64` (F=39) → `mem_wr_ptr=35` (wrap), and the next head fetches from address 35.
- `host_wr_ptr` advanced only to head+20 for a 39-word frame → stays in `S_CHECK`; releases 2 cycles after `host_wr_ptr` reaches head+39.
- `frame_len=2000` → `sched_err=1`, `mem_wr_ptr` unchanged. Then `sys_rst` → all outputs 0 and `sched_err=0`.
